// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared rv32i types, fetch FSM states and control vectors for the hazard controller
package hazard_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 32;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [4:0] reg_idx_t;
  typedef enum logic [1:0] {FETCH, HELD, DROP} fetch_state_e;
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;
  localparam pipe_ctrl_t CTRL_RESET    = 7'b0111111;
  localparam pipe_ctrl_t CTRL_DSTALL   = 7'b0000000;
  localparam pipe_ctrl_t CTRL_REDIRECT = 7'b1111111;
  localparam pipe_ctrl_t CTRL_LDUSE    = 7'b0011101;
  localparam pipe_ctrl_t CTRL_BUBBLE   = 7'b0111110;
  localparam pipe_ctrl_t CTRL_ADVANCE  = 7'b1111100;
  function automatic logic reads_reg(input logic uses, input reg_idx_t rs, input reg_idx_t rd);
    return uses && rs == rd;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: instruction fetch handshake and data-memory status seen by the hazard controller
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;
  logic imem_read;
  logic imem_resp;
  word_t imem_rdata;
  logic dmem_req;
  logic dmem_resp;
  modport master(output imem_read, input imem_resp, imem_rdata, dmem_req, dmem_resp);
  modport slave(input imem_read, output imem_resp, imem_rdata, dmem_req, dmem_resp);
endinterface

// File: rtl/hazard_ctrl_perf_counter.sv
// perf_counter: saturating event counter with synchronous active-low clear
module perf_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  // count events, holding at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    count <= !rst ? '0 : (inc && count != '1) ? count + 1'b1 : count;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush arbitration with a fetch-word hold buffer and perf counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.master    bus,
  input  logic             idex_is_load,
  input  reg_idx_t         idex_rd,
  input  reg_idx_t         ifid_rs1,
  input  reg_idx_t         ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic             ex_redirect,
  output word_t            instr_out,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  fetch_state_e state;
  word_t buffer;
  pipe_ctrl_t ctrl;
  logic dstall, lduse, fetch_ok, redirect;
  assign dstall = bus.dmem_req && !bus.dmem_resp;
  assign lduse = idex_is_load && idex_rd != '0 &&
                 (reads_reg(ifid_uses_rs1, ifid_rs1, idex_rd) || reads_reg(ifid_uses_rs2, ifid_rs2, idex_rd));
  assign fetch_ok = (state == FETCH && bus.imem_resp) || state == HELD;
  assign redirect = ex_redirect && !dstall;
  // one action per cycle, highest priority first
  always_comb begin
    ctrl = !rst ? CTRL_RESET : dstall ? CTRL_DSTALL : ex_redirect ? CTRL_REDIRECT :
           lduse ? CTRL_LDUSE : !fetch_ok ? CTRL_BUBBLE : CTRL_ADVANCE;
  end
  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = ctrl;
  assign bus.imem_read = rst && state != HELD;
  assign instr_out = !rst ? '0 : state == HELD ? buffer : bus.imem_rdata;
  // fetch FSM: park a returned word while IF/ID is frozen, drop a word fetched down a stale path
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FETCH;
      buffer <= '0;
    end else begin
      case (state)
        FETCH:
          if (bus.imem_resp && (dstall || (lduse && !ex_redirect))) begin
            buffer <= bus.imem_rdata;
            state <= HELD;
          end else if (redirect && !bus.imem_resp) state <= DROP;
        HELD: if (!dstall && (ex_redirect || !lduse)) state <= FETCH;
        DROP: if (bus.imem_resp) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end
  perf_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(!pc_en), .count(stall_cycles));
  perf_counter #(.W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(redirect), .count(flush_count));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against an action-level model
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  hazard_ctrl_if bus();
  logic idex_is_load, ifid_uses_rs1, ifid_uses_rs2, ex_redirect;
  reg_idx_t idex_rd, ifid_rs1, ifid_rs2;
  word_t instr_out;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [31:0] stall_cycles, flush_count;
  logic sat_inc = 1'b0;
  logic [1:0] sat_count;
  int checks = 0;
  int failures = 0;
  bit m_held, m_drop;
  word_t m_word;
  longint m_stall, m_flush;
  // rows: reset, dstall, redirect, lduse, bubble, advance as {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}
  logic [6:0] act_tbl [6] = '{7'b0111111, 7'b0000000, 7'b1111111, 7'b0011101, 7'b0111110, 7'b1111100};

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .idex_is_load(idex_is_load), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2), .ex_redirect(ex_redirect),
    .instr_out(instr_out), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  perf_counter #(.W(2)) u_sat (.clk(clk), .rst(rst), .inc(sat_inc), .count(sat_count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.imem_resp = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_resp = 1'b0;
    ex_redirect = 1'b0;
    idex_is_load = 1'b0;
    idex_rd = '0;
    ifid_rs1 = '0;
    ifid_rs2 = '0;
    ifid_uses_rs1 = 1'b0;
    ifid_uses_rs2 = 1'b0;
  endtask

  task automatic cycle(input string tag);
    logic ds, lu, ready, exp_pc;
    int act;
    #2;
    ds = bus.dmem_req && !bus.dmem_resp;
    lu = idex_is_load && idex_rd != 0 &&
         ((ifid_uses_rs1 && ifid_rs1 == idex_rd) || (ifid_uses_rs2 && ifid_rs2 == idex_rd));
    ready = m_held || (!m_drop && bus.imem_resp);
    act = !rst ? 0 : ds ? 1 : ex_redirect ? 2 : lu ? 3 : !ready ? 4 : 5;
    exp_pc = act_tbl[act][6];
    check({tag, "/ctl"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}), 32'(act_tbl[act]));
    check({tag, "/imem_read"}, 32'(bus.imem_read), 32'(rst && !m_held));
    if (!rst) check({tag, "/instr"}, instr_out, 0);
    else if (m_held) check({tag, "/instr"}, instr_out, m_word);
    else if (!m_drop) check({tag, "/instr"}, instr_out, bus.imem_rdata);
    check({tag, "/stall_cycles"}, stall_cycles, 32'(m_stall));
    check({tag, "/flush_count"}, flush_count, 32'(m_flush));
    @(posedge clk);
    if (!rst) begin
      m_held = 0; m_drop = 0; m_word = '0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_pc && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (act == 2 && m_flush < 64'hFFFF_FFFF) m_flush++;
      if (m_held) m_held = !(act == 2 || act == 5);
      else if (m_drop) m_drop = !bus.imem_resp;
      else if (bus.imem_resp && (act == 1 || act == 3)) begin
        m_held = 1; m_word = bus.imem_rdata;
      end else if (act == 2 && !bus.imem_resp) m_drop = 1;
    end
    #1;
  endtask

  initial begin
    idle();
    bus.imem_rdata = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_en", pc_en, 0);
    check("rst_flushes", {ifid_flush, idex_flush}, 2'b11);
    check("rst_imem_read", bus.imem_read, 0);
    check("rst_instr", instr_out, 0);
    cycle("rst");
    check("rst_stall_cnt", stall_cycles, 0);
    check("rst_flush_cnt", flush_count, 0);
    rst = 1'b1;
    repeat (3) cycle("miss");
    check("miss_stall_cnt", stall_cycles, 3);
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'h00A00093;
    #1;
    check("hit_instr", instr_out, 32'h00A00093);
    check("hit_pc_en", pc_en, 1);
    cycle("hit");
    check("hit_stall_cnt", stall_cycles, 3);
    idex_is_load = 1'b1; idex_rd = 5'd5; ifid_uses_rs2 = 1'b1; ifid_rs2 = 5'd5;
    bus.imem_rdata = 32'hCAFE0013;
    #1;
    check("lduse_stall", {pc_en, ifid_en, idex_flush}, 3'b001);
    cycle("lduse");
    idle();
    #1;
    check("lduse_held_read", bus.imem_read, 0);
    check("lduse_held_instr", instr_out, 32'hCAFE0013);
    check("lduse_release_pc", pc_en, 1);
    cycle("lduse_rel");
    idex_is_load = 1'b1; idex_rd = 5'd0; ifid_uses_rs2 = 1'b1; ifid_rs2 = 5'd0;
    bus.imem_resp = 1'b1; bus.imem_rdata = 32'h00000513;
    #1;
    check("rd0_no_stall", pc_en, 1);
    cycle("rd0");
    idle();
    bus.imem_resp = 1'b1; bus.imem_rdata = 32'h12345678; bus.dmem_req = 1'b1;
    #1;
    check("dstall_ens", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
    cycle("dstall1");
    bus.imem_resp = 1'b0; bus.imem_rdata = 32'hDEADBEEF;
    #1;
    check("dstall_held_read", bus.imem_read, 0);
    cycle("dstall2");
    bus.dmem_resp = 1'b1;
    #1;
    check("dstall_rel_instr", instr_out, 32'h12345678);
    check("dstall_rel_ifid", {ifid_en, ifid_flush}, 2'b10);
    cycle("dstall_rel");
    idle();
    ex_redirect = 1'b1;
    #1;
    check("redir_flushes", {ifid_flush, idex_flush}, 2'b11);
    cycle("redir");
    check("redir_flush_cnt", flush_count, 1);
    idle();
    #1;
    check("drop_read", bus.imem_read, 1);
    cycle("drop_wait");
    bus.imem_resp = 1'b1; bus.imem_rdata = 32'hBAD00000;
    #1;
    check("drop_discard", {pc_en, ifid_flush}, 2'b01);
    cycle("drop_resp");
    bus.imem_rdata = 32'h00100073;
    #1;
    check("refetch_instr", instr_out, 32'h00100073);
    check("refetch_flush", ifid_flush, 0);
    cycle("refetch");
    idle();
    ex_redirect = 1'b1; bus.dmem_req = 1'b1;
    #1;
    check("ds_redir_noflush", {ifid_flush, idex_flush}, 2'b00);
    cycle("ds_redir");
    check("ds_redir_cnt", flush_count, 1);
    bus.dmem_resp = 1'b1;
    #1;
    check("ds_redir_rel_flush", {ifid_flush, idex_flush}, 2'b11);
    cycle("ds_redir_rel");
    check("ds_redir_rel_cnt", flush_count, 2);
    idle();
    rst = 1'b0;
    cycle("rst_in_drop");
    rst = 1'b1;
    #1;
    check("post_drop_read", bus.imem_read, 1);
    check("post_drop_stall", stall_cycles, 0);
    check("post_drop_flush", flush_count, 0);
    bus.imem_resp = 1'b1; bus.dmem_req = 1'b1; bus.imem_rdata = 32'h0BADF00D;
    cycle("to_held");
    idle();
    rst = 1'b0;
    cycle("rst_in_held");
    rst = 1'b1;
    bus.imem_resp = 1'b1; bus.imem_rdata = 32'h00000013;
    #1;
    check("post_held_read", bus.imem_read, 1);
    check("post_held_instr", instr_out, 32'h00000013);
    cycle("after_rst");
    idle();
    sat_inc = 1'b1;
    repeat (2) cycle("sat_fill");
    check("sat_near_max", sat_count, 2);
    repeat (3) cycle("sat_hold");
    check("sat_saturated", sat_count, 3);
    sat_inc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(24) != 0);
      bus.dmem_req = ($urandom_range(2) == 0);
      bus.dmem_resp = 1'($urandom_range(1));
      ex_redirect = ($urandom_range(5) == 0);
      idex_is_load = 1'($urandom_range(1));
      idex_rd = 5'($urandom_range(3));
      ifid_rs1 = 5'($urandom_range(3));
      ifid_rs2 = 5'($urandom_range(3));
      ifid_uses_rs1 = 1'($urandom_range(1));
      ifid_uses_rs2 = 1'($urandom_range(1));
      bus.imem_resp = 1'($urandom_range(1));
      bus.imem_rdata = $urandom;
      cycle("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
